mult_for: RTL and testbench

MULT_FOR -- requirements
Module: mult_for

---
 rtl/mult_for.sv | 35 +++
 tb/tb_mult_for.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mult_for.sv
// Unsigned shift-and-add multiplier with a single registered output stage.
// The product is formed combinationally at full 2*size width and captured every clock.
module mult_for #(
  parameter int size = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [size-1:0]     a,
  input  logic [size-1:0]     b,
  output logic [2*size-1:0]   outcome
);

  logic [2*size-1:0] a_ext;
  logic [2*size-1:0] product;

  // Partial products and running sum at full width so the widest result never truncates.
  always_comb begin
    a_ext   = {{size{1'b0}}, a};
    product = '0;
    for (int i = 0; i < size; i++) begin
      if (b[i]) begin
        product = product + (a_ext << i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      outcome <= '0;
    end else begin
      outcome <= product;
    end
  end

endmodule

// File: tb/tb_mult_for.sv
// Self-checking bench for mult_for: table-driven directed vectors at size 8,
// width checks at size 4 and 16, random streaming and reset corner cases.
module tb_mult_for;

  logic        clk;
  logic        rstn;
  logic [7:0]  a8, b8;
  logic [15:0] o8;
  logic [3:0]  a4, b4;
  logic [7:0]  o4;
  logic [15:0] a16, b16;
  logic [31:0] o16;

  int n_checks;
  int n_fail;

  mult_for #(.size(8))  dut8  (.clk(clk), .rstn(rstn), .a(a8),  .b(b8),  .outcome(o8));
  mult_for #(.size(4))  dut4  (.clk(clk), .rstn(rstn), .a(a4),  .b(b4),  .outcome(o4));
  mult_for #(.size(16)) dut16 (.clk(clk), .rstn(rstn), .a(a16), .b(b16), .outcome(o16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rstn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp8;
    logic [7:0]  exp4;
    logic [31:0] exp16;
    logic [15:0] held;

    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{"reset_edge1",   1'b0, 8'hFF, 8'hFF, 16'h0000};
    vecs[1] = '{"reset_edge2",   1'b0, 8'hFF, 8'hFF, 16'h0000};
    vecs[2] = '{"max_ff_ff",     1'b1, 8'hFF, 8'hFF, 16'hFE01};
    vecs[3] = '{"a_zero",        1'b1, 8'h00, 8'hA5, 16'h0000};
    vecs[4] = '{"a_one",         1'b1, 8'h01, 8'hA5, 16'h00A5};
    vecs[5] = '{"msb_times_two", 1'b1, 8'h80, 8'h02, 16'h0100};
    vecs[6] = '{"b_one",         1'b1, 8'hC3, 8'h01, 16'h00C3};
    vecs[7] = '{"b_zero",        1'b1, 8'h7E, 8'h00, 16'h0000};
    vecs[8] = '{"midrst_hold",   1'b0, 8'h12, 8'h34, 16'h0000};
    vecs[9] = '{"midrst_release",1'b1, 8'h12, 8'h34, 16'h03A8};

    // Narrow and wide instances ride along with max operands throughout the table.
    a4  = 4'hF;    b4  = 4'hF;
    a16 = 16'hFFFF; b16 = 16'hFFFF;
    rstn = 1'b0; a8 = 8'hFF; b8 = 8'hFF;

    for (int i = 0; i < 10; i++) begin
      rstn = vecs[i].rstn;
      a8   = vecs[i].a;
      b8   = vecs[i].b;
      tick();
      check(vecs[i].name, {16'h0, o8}, {16'h0, vecs[i].exp});
      check({vecs[i].name, "_s4"},  {24'h0, o4}, vecs[i].rstn ? 32'h0000_00E1 : 32'h0);
      check({vecs[i].name, "_s16"}, o16,         vecs[i].rstn ? 32'hFFFE_0001 : 32'h0);
    end

    // Reset deasserted-to-asserted between edges must not move the output.
    rstn = 1'b1; a8 = 8'h0F; b8 = 8'h11;
    tick();
    check("pre_async", {16'h0, o8}, 32'h0000_00FF);
    rstn = 1'b0;
    #3;
    check("no_async_clear", {16'h0, o8}, 32'h0000_00FF);
    a8 = 8'h02;
    #1;
    check("stable_between_edges", {16'h0, o8}, 32'h0000_00FF);
    tick();
    check("sync_clear", {16'h0, o8}, 32'h0);
    rstn = 1'b1;
    #2;
    check("no_async_release", {16'h0, o8}, 32'h0);
    tick();
    check("first_edge_after_release", {16'h0, o8}, 32'h0000_0022);

    // Random streaming: new operands every edge, compare against previous edge's product.
    held = 16'h0;
    for (int n = 0; n < 1000; n++) begin
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      a4  = 4'($urandom);
      b4  = 4'($urandom);
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      exp8  = {8'h0, a8} * {8'h0, b8};
      exp4  = {4'h0, a4} * {4'h0, b4};
      exp16 = {16'h0, a16} * {16'h0, b16};
      tick();
      check("stream_s8",  {16'h0, o8}, {16'h0, exp8});
      check("stream_s4",  {24'h0, o4}, {24'h0, exp4});
      check("stream_s16", o16,         exp16);
      held = exp8;
    end

    // Output must hold its last value while no edge occurs even if operands change.
    a8 = ~a8; b8 = ~b8;
    #3;
    check("hold_after_stream", {16'h0, o8}, {16'h0, held});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
